// File: rtl/ysyx_041461_pipe_ctrl.sv
// Valid/stall controller for the 6-stage pipeline (IF, IF2, ID, EXE, MEM, WB):
// stage valid bits, register load enables, PC hold, trap flush and ID-stall counter.
module ysyx_041461_pipe_ctrl #(
  parameter int         CNT_W    = 32,
  parameter logic [3:0] TRAP_NOP = 4'd0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             IF_valid_in,
  input  logic             IF2_ready,
  input  logic             MEM_ready,
  input  logic             ID_redirect,
  input  logic [3:0]       WB_trap_in,
  input  logic             CD_ID_conflict,
  input  logic             CD_EXE_conflict,
  input  logic             CD_MEM_conflict,
  input  logic             CD_IF_trap,
  input  logic             CD_IF2_trap,
  input  logic             CD_ID_trap,
  input  logic             CD_EXE_trap,
  input  logic             CD_MEM_trap,
  output logic             IF2_valid,
  output logic             ID_valid,
  output logic             EXE_valid,
  output logic             MEM_valid,
  output logic             WB_valid,
  output logic             IF2_en,
  output logic             ID_en,
  output logic             EXE_en,
  output logic             MEM_en,
  output logic             WB_en,
  output logic             PC_hold,
  output logic             trap_redirect,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic {RUN, FLUSH} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t state;

  logic run;
  logic c_id, c_exe, c_mem;
  logic stall_if2, stall_id, stall_exe, stall_mem;
  logic fwd_if, fwd_if2, fwd_id, fwd_exe, fwd_mem;
  logic redir, tc;

  // A stage that is being killed by an older trap never raises a hazard stall.
  assign c_id  = CD_ID_conflict  & ~CD_ID_trap;
  assign c_exe = CD_EXE_conflict & ~CD_EXE_trap;
  assign c_mem = CD_MEM_conflict & ~CD_MEM_trap;

  assign stall_mem = c_mem | ~MEM_ready;
  assign stall_exe = c_exe | stall_mem;
  assign stall_id  = c_id  | stall_exe;
  assign stall_if2 = stall_id | ~IF2_ready;

  assign run     = (state == RUN);
  assign IF2_en  = run & ~stall_if2;
  assign ID_en   = run & ~stall_id;
  assign EXE_en  = run & ~stall_exe;
  assign MEM_en  = run & ~stall_mem;
  assign WB_en   = run;
  assign PC_hold = ~run | stall_if2;

  assign fwd_if  = IF_valid_in & ~stall_if2 & ~CD_IF_trap;
  assign fwd_if2 = IF2_valid   & ~stall_if2 & ~CD_IF2_trap;
  assign fwd_id  = ID_valid    & ~stall_id  & ~CD_ID_trap;
  assign fwd_exe = EXE_valid   & ~stall_exe & ~CD_EXE_trap;
  assign fwd_mem = MEM_valid   & ~stall_mem & ~CD_MEM_trap;

  assign redir = ID_valid & ID_redirect & ~stall_id & ~CD_ID_trap;
  assign tc    = WB_valid & (WB_trap_in != TRAP_NOP);

  // Trap commit wins over redirects and stalls; the redirect pulse marks the FLUSH exit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= RUN;
      IF2_valid     <= 1'b0;
      ID_valid      <= 1'b0;
      EXE_valid     <= 1'b0;
      MEM_valid     <= 1'b0;
      WB_valid      <= 1'b0;
      trap_redirect <= 1'b0;
      stall_cnt     <= '0;
    end else begin
      case (state)
        RUN: begin
          trap_redirect <= 1'b0;
          if (tc) begin
            state     <= FLUSH;
            IF2_valid <= 1'b0;
            ID_valid  <= 1'b0;
            EXE_valid <= 1'b0;
            MEM_valid <= 1'b0;
            WB_valid  <= 1'b0;
          end else begin
            if (redir) begin
              IF2_valid <= 1'b0;
              ID_valid  <= 1'b0;
            end else begin
              IF2_valid <= IF2_en ? fwd_if  : (IF2_valid & ~CD_IF2_trap);
              ID_valid  <= ID_en  ? fwd_if2 : (ID_valid  & ~CD_ID_trap);
            end
            EXE_valid <= EXE_en ? fwd_id  : (EXE_valid & ~CD_EXE_trap);
            MEM_valid <= MEM_en ? fwd_exe : (MEM_valid & ~CD_MEM_trap);
            WB_valid  <= fwd_mem;
            if (ID_valid && stall_id && stall_cnt != CNT_MAX) begin
              stall_cnt <= stall_cnt + CNT_ONE;
            end
          end
        end
        FLUSH: begin
          IF2_valid <= 1'b0;
          ID_valid  <= 1'b0;
          EXE_valid <= 1'b0;
          MEM_valid <= 1'b0;
          WB_valid  <= 1'b0;
          if (MEM_ready) begin
            state         <= RUN;
            trap_redirect <= 1'b1;
          end else begin
            trap_redirect <= 1'b0;
          end
        end
        default: begin
          state         <= RUN;
          trap_redirect <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_041461_pipe_ctrl.sv
// Directed bench for ysyx_041461_pipe_ctrl; a second instance with a 2-bit
// counter covers saturation.
module tb_ysyx_041461_pipe_ctrl;

  logic clk, rst_n;
  logic IF_valid_in, IF2_ready, MEM_ready, ID_redirect;
  logic [3:0] WB_trap_in;
  logic CD_ID_conflict, CD_EXE_conflict, CD_MEM_conflict;
  logic CD_IF_trap, CD_IF2_trap, CD_ID_trap, CD_EXE_trap, CD_MEM_trap;
  logic IF2_valid, ID_valid, EXE_valid, MEM_valid, WB_valid;
  logic IF2_en, ID_en, EXE_en, MEM_en, WB_en;
  logic PC_hold, trap_redirect;
  logic [31:0] stall_cnt;

  logic s_IF2_valid, s_ID_valid, s_EXE_valid, s_MEM_valid, s_WB_valid;
  logic s_IF2_en, s_ID_en, s_EXE_en, s_MEM_en, s_WB_en, s_PC_hold, s_trap_redirect;
  logic [1:0] s_stall_cnt;

  logic [4:0] valids, ens, exp;
  int n_cmp, n_fail;

  assign valids = {IF2_valid, ID_valid, EXE_valid, MEM_valid, WB_valid};
  assign ens    = {IF2_en, ID_en, EXE_en, MEM_en, WB_en};

  ysyx_041461_pipe_ctrl dut (
    .clk(clk), .rst_n(rst_n), .IF_valid_in(IF_valid_in), .IF2_ready(IF2_ready),
    .MEM_ready(MEM_ready), .ID_redirect(ID_redirect), .WB_trap_in(WB_trap_in),
    .CD_ID_conflict(CD_ID_conflict), .CD_EXE_conflict(CD_EXE_conflict),
    .CD_MEM_conflict(CD_MEM_conflict), .CD_IF_trap(CD_IF_trap), .CD_IF2_trap(CD_IF2_trap),
    .CD_ID_trap(CD_ID_trap), .CD_EXE_trap(CD_EXE_trap), .CD_MEM_trap(CD_MEM_trap),
    .IF2_valid(IF2_valid), .ID_valid(ID_valid), .EXE_valid(EXE_valid),
    .MEM_valid(MEM_valid), .WB_valid(WB_valid), .IF2_en(IF2_en), .ID_en(ID_en),
    .EXE_en(EXE_en), .MEM_en(MEM_en), .WB_en(WB_en), .PC_hold(PC_hold),
    .trap_redirect(trap_redirect), .stall_cnt(stall_cnt)
  );

  ysyx_041461_pipe_ctrl #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .IF_valid_in(IF_valid_in), .IF2_ready(IF2_ready),
    .MEM_ready(MEM_ready), .ID_redirect(ID_redirect), .WB_trap_in(WB_trap_in),
    .CD_ID_conflict(CD_ID_conflict), .CD_EXE_conflict(CD_EXE_conflict),
    .CD_MEM_conflict(CD_MEM_conflict), .CD_IF_trap(CD_IF_trap), .CD_IF2_trap(CD_IF2_trap),
    .CD_ID_trap(CD_ID_trap), .CD_EXE_trap(CD_EXE_trap), .CD_MEM_trap(CD_MEM_trap),
    .IF2_valid(s_IF2_valid), .ID_valid(s_ID_valid), .EXE_valid(s_EXE_valid),
    .MEM_valid(s_MEM_valid), .WB_valid(s_WB_valid), .IF2_en(s_IF2_en), .ID_en(s_ID_en),
    .EXE_en(s_EXE_en), .MEM_en(s_MEM_en), .WB_en(s_WB_en), .PC_hold(s_PC_hold),
    .trap_redirect(s_trap_redirect), .stall_cnt(s_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    IF_valid_in = 1'b0; IF2_ready = 1'b1; MEM_ready = 1'b1; ID_redirect = 1'b0;
    WB_trap_in = 4'd0;
    CD_ID_conflict = 1'b0; CD_EXE_conflict = 1'b0; CD_MEM_conflict = 1'b0;
    CD_IF_trap = 1'b0; CD_IF2_trap = 1'b0; CD_ID_trap = 1'b0;
    CD_EXE_trap = 1'b0; CD_MEM_trap = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Five clean cycles with a steady fetch stream leave every stage valid.
  task automatic fill();
    idle();
    IF_valid_in = 1'b1;
    repeat (5) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    #12;
    n_cmp++; if (valids !== 5'b00000) begin n_fail++; $display("[TB] FAIL reset_valids: got %b want 00000", valids); end
    n_cmp++; if (trap_redirect !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_trap_redirect: got %b want 0", trap_redirect); end
    n_cmp++; if (stall_cnt !== 32'd0) begin n_fail++; $display("[TB] FAIL reset_stall_cnt: got %0d want 0", stall_cnt); end
    n_cmp++; if ({ens, PC_hold} !== 6'b111110) begin n_fail++; $display("[TB] FAIL reset_en_hold: got %b want 111110", {ens, PC_hold}); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_free_run();
    idle();
    IF_valid_in = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      exp = ~(5'b11111 >> k);
      n_cmp++; if (valids !== exp) begin n_fail++; $display("[TB] FAIL free_run_valids[%0d]: got %b want %b", k, valids, exp); end
    end
    n_cmp++; if ({ens, PC_hold} !== 6'b111110) begin n_fail++; $display("[TB] FAIL free_run_en_hold: got %b want 111110", {ens, PC_hold}); end
    n_cmp++; if (stall_cnt !== 32'd0) begin n_fail++; $display("[TB] FAIL free_run_stall_cnt: got %0d want 0", stall_cnt); end
  endtask

  task automatic test_id_stall();
    CD_ID_conflict = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if ({ens, PC_hold} !== 6'b001111) begin n_fail++; $display("[TB] FAIL id_stall_en_hold[%0d]: got %b want 001111", i, {ens, PC_hold}); end
      tick();
      n_cmp++; if (EXE_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL id_stall_bubble[%0d]: got %b want 0", i, EXE_valid); end
    end
    CD_ID_conflict = 1'b0;
    n_cmp++; if (valids !== 5'b11000) begin n_fail++; $display("[TB] FAIL id_stall_valids: got %b want 11000", valids); end
    n_cmp++; if (stall_cnt !== 32'd3) begin n_fail++; $display("[TB] FAIL id_stall_cnt: got %0d want 3", stall_cnt); end
    n_cmp++; if (s_stall_cnt !== 2'd3) begin n_fail++; $display("[TB] FAIL id_stall_cnt_small: got %0d want 3", s_stall_cnt); end
    tick();
    n_cmp++; if (valids !== 5'b11100) begin n_fail++; $display("[TB] FAIL id_stall_release: got %b want 11100", valids); end
    tick();
    tick();
    n_cmp++; if (valids !== 5'b11111) begin n_fail++; $display("[TB] FAIL id_stall_refill: got %b want 11111", valids); end
  endtask

  task automatic test_mem_stall();
    MEM_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_cmp++; if ({ens, PC_hold} !== 6'b000011) begin n_fail++; $display("[TB] FAIL mem_stall_en_hold[%0d]: got %b want 000011", i, {ens, PC_hold}); end
      tick();
      n_cmp++; if ({MEM_valid, WB_valid} !== 2'b10) begin n_fail++; $display("[TB] FAIL mem_stall_mem_wb[%0d]: got %b want 10", i, {MEM_valid, WB_valid}); end
    end
    MEM_ready = 1'b1;
    n_cmp++; if (valids !== 5'b11110) begin n_fail++; $display("[TB] FAIL mem_stall_held: got %b want 11110", valids); end
    n_cmp++; if (stall_cnt !== 32'd5) begin n_fail++; $display("[TB] FAIL mem_stall_cnt: got %0d want 5", stall_cnt); end
    tick();
    n_cmp++; if (valids !== 5'b11111) begin n_fail++; $display("[TB] FAIL mem_stall_release: got %b want 11111", valids); end
  endtask

  task automatic test_redirect();
    ID_redirect = 1'b1;
    tick();
    ID_redirect = 1'b0;
    n_cmp++; if (valids !== 5'b00111) begin n_fail++; $display("[TB] FAIL redirect_squash: got %b want 00111", valids); end
    tick();
    n_cmp++; if (valids !== 5'b10011) begin n_fail++; $display("[TB] FAIL redirect_after: got %b want 10011", valids); end
    fill();
    // A stalled ID must not redirect, so nothing is squashed.
    CD_ID_conflict = 1'b1;
    ID_redirect = 1'b1;
    tick();
    n_cmp++; if (valids !== 5'b11011) begin n_fail++; $display("[TB] FAIL redirect_stalled: got %b want 11011", valids); end
    n_cmp++; if (stall_cnt !== 32'd6) begin n_fail++; $display("[TB] FAIL redirect_stall_cnt: got %0d want 6", stall_cnt); end
    fill();
  endtask

  task automatic test_kill();
    CD_EXE_conflict = 1'b1; CD_ID_conflict = 1'b1;
    CD_IF_trap = 1'b1; CD_IF2_trap = 1'b1; CD_ID_trap = 1'b1; CD_EXE_trap = 1'b1;
    #1;
    n_cmp++; if ({ens, PC_hold} !== 6'b111110) begin n_fail++; $display("[TB] FAIL kill_no_stall: got %b want 111110", {ens, PC_hold}); end
    tick();
    n_cmp++; if (valids !== 5'b00001) begin n_fail++; $display("[TB] FAIL kill_valids: got %b want 00001", valids); end
    n_cmp++; if (stall_cnt !== 32'd6) begin n_fail++; $display("[TB] FAIL kill_stall_cnt: got %0d want 6", stall_cnt); end
    fill();
    // Held stages must still drop instructions an older trap kills.
    IF_valid_in = 1'b1; MEM_ready = 1'b0;
    CD_IF_trap = 1'b1; CD_IF2_trap = 1'b1; CD_ID_trap = 1'b1;
    tick();
    n_cmp++; if (valids !== 5'b00110) begin n_fail++; $display("[TB] FAIL kill_held: got %b want 00110", valids); end
    n_cmp++; if (stall_cnt !== 32'd7) begin n_fail++; $display("[TB] FAIL kill_held_cnt: got %0d want 7", stall_cnt); end
    fill();
  endtask

  task automatic test_trap();
    WB_trap_in = 4'd2;
    #1;
    n_cmp++; if (ens !== 5'b11111) begin n_fail++; $display("[TB] FAIL trap_commit_en: got %b want 11111", ens); end
    tick();
    n_cmp++; if ({valids, ens, PC_hold, trap_redirect} !== 12'b000000000010) begin n_fail++; $display("[TB] FAIL trap_flush: got %b want 000000000010", {valids, ens, PC_hold, trap_redirect}); end
    tick();
    n_cmp++; if ({trap_redirect, valids, ens} !== 11'b10000011111) begin n_fail++; $display("[TB] FAIL trap_pulse: got %b want 10000011111", {trap_redirect, valids, ens}); end
    tick();
    WB_trap_in = 4'd0;
    n_cmp++; if ({trap_redirect, valids} !== 6'b010000) begin n_fail++; $display("[TB] FAIL trap_pulse_end: got %b want 010000", {trap_redirect, valids}); end
    fill();
    WB_trap_in = 4'd2;
    tick();
    WB_trap_in = 4'd0;
    MEM_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if ({trap_redirect, valids, PC_hold} !== 7'b0000001) begin n_fail++; $display("[TB] FAIL trap_long_flush[%0d]: got %b want 0000001", i, {trap_redirect, valids, PC_hold}); end
      MEM_ready = (i == 3);
      tick();
    end
    n_cmp++; if (trap_redirect !== 1'b1) begin n_fail++; $display("[TB] FAIL trap_long_pulse: got %b want 1", trap_redirect); end
    tick();
    n_cmp++; if (trap_redirect !== 1'b0) begin n_fail++; $display("[TB] FAIL trap_long_pulse_end: got %b want 0", trap_redirect); end
    n_cmp++; if (stall_cnt !== 32'd7) begin n_fail++; $display("[TB] FAIL trap_stall_cnt: got %0d want 7", stall_cnt); end
    n_cmp++; if (s_stall_cnt !== 2'd3) begin n_fail++; $display("[TB] FAIL trap_stall_cnt_sat: got %0d want 3", s_stall_cnt); end
  endtask

  task automatic test_reset_flush();
    fill();
    WB_trap_in = 4'd2;
    tick();
    WB_trap_in = 4'd0;
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({valids, trap_redirect} !== 6'b000000) begin n_fail++; $display("[TB] FAIL rst_flush_valids: got %b want 000000", {valids, trap_redirect}); end
    n_cmp++; if ({ens, PC_hold} !== 6'b111110) begin n_fail++; $display("[TB] FAIL rst_flush_state: got %b want 111110", {ens, PC_hold}); end
    n_cmp++; if ({stall_cnt, s_stall_cnt} !== 34'd0) begin n_fail++; $display("[TB] FAIL rst_flush_cnt: got %0d/%0d want 0/0", stall_cnt, s_stall_cnt); end
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_cmp++; if (trap_redirect !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_flush_no_pulse: got %b want 0", trap_redirect); end
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    test_reset();
    test_free_run();
    test_id_stall();
    test_mem_stall();
    test_redirect();
    test_kill();
    test_trap();
    test_reset_flush();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
